// File: rtl/exc_div.sv
// LVDT excitation divider: down-counter producing a one-cycle carry every D mclk cycles and a 2*D square wave.
// Optional quadrature excitation output exc_quad is enabled by defining EXC_DIV_QUAD_EN.
module exc_div #(
    parameter int WIDTH     = 16,
    parameter int DIV_RESET = 100
) (
    input  logic             mclk,
    input  logic             rst,
    input  logic             en,
    input  logic             div_ld,
    input  logic [WIDTH-1:0] div_val,
    output logic             carry,
    output logic             exc_sq,
    output logic [WIDTH-1:0] cnt,
    output logic             ld_pend
`ifdef EXC_DIV_QUAD_EN
    ,
    output logic             exc_quad
`endif
);

    typedef enum logic {IDLE, RUN} state_t;

    localparam logic [WIDTH-1:0] DIV_RST_V = WIDTH'((DIV_RESET < 2) ? 2 : DIV_RESET);

    // Divisors below 2 would make D-1 reach zero or wrap, so they saturate at 2.
    function automatic logic [WIDTH-1:0] clamp_div(input logic [WIDTH-1:0] v);
        return (v < WIDTH'(2)) ? WIDTH'(2) : v;
    endfunction

    state_t           state;
    logic [WIDTH-1:0] div_act;
    logic [WIDTH-1:0] div_shd;
    logic [WIDTH-1:0] div_new;

    assign div_new = clamp_div(div_val);

`ifdef EXC_DIV_QUAD_EN
    logic             had_carry;
    logic [WIDTH-1:0] quad_pt;

    // Toggle point is floor(D/2) edges after the reload, i.e. when cnt equals ceil(D/2).
    assign quad_pt = div_act - (div_act >> 1);
`endif

    always_ff @(posedge mclk) begin
        if (!rst) begin
            state   <= IDLE;
            cnt     <= '0;
            carry   <= 1'b0;
            exc_sq  <= 1'b0;
            ld_pend <= 1'b0;
            div_act <= DIV_RST_V;
            div_shd <= DIV_RST_V;
`ifdef EXC_DIV_QUAD_EN
            exc_quad  <= 1'b0;
            had_carry <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    carry   <= 1'b0;
                    exc_sq  <= 1'b0;
                    ld_pend <= 1'b0;
                    cnt     <= '0;
                    if (div_ld) begin
                        div_act <= div_new;
                        div_shd <= div_new;
                    end
                    if (en) begin
                        state <= RUN;
                        cnt   <= (div_ld ? div_new : div_act) - 1'b1;
                    end
                end

                RUN: begin
                    if (!en) begin
                        state   <= IDLE;
                        cnt     <= '0;
                        carry   <= 1'b0;
                        exc_sq  <= 1'b0;
                        ld_pend <= 1'b0;
`ifdef EXC_DIV_QUAD_EN
                        exc_quad  <= 1'b0;
                        had_carry <= 1'b0;
`endif
                        if (div_ld) begin
                            div_act <= div_new;
                            div_shd <= div_new;
                        end else if (ld_pend) begin
                            div_act <= div_shd;
                        end
                    end else if (cnt == '0) begin
                        // Reload edge: period boundary, pending divisor takes effect here.
                        carry   <= 1'b1;
                        exc_sq  <= ~exc_sq;
                        ld_pend <= 1'b0;
`ifdef EXC_DIV_QUAD_EN
                        had_carry <= 1'b1;
`endif
                        if (div_ld) begin
                            div_act <= div_new;
                            div_shd <= div_new;
                            cnt     <= div_new - 1'b1;
                        end else if (ld_pend) begin
                            div_act <= div_shd;
                            cnt     <= div_shd - 1'b1;
                        end else begin
                            cnt     <= div_act - 1'b1;
                        end
                    end else begin
                        carry <= 1'b0;
                        cnt   <= cnt - 1'b1;
                        if (div_ld) begin
                            div_shd <= div_new;
                            ld_pend <= 1'b1;
                        end
`ifdef EXC_DIV_QUAD_EN
                        if (had_carry && (cnt == quad_pt)) begin
                            exc_quad <= ~exc_quad;
                        end
`endif
                    end
                end

                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                    carry <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_exc_div.sv
// Randomized and directed bench for exc_div against a timestamp-based behavioural model.
// Also checks exc_quad when EXC_DIV_QUAD_EN is defined.
module tb_exc_div;

    localparam int W  = 16;
    localparam int DR = 100;

    logic         mclk = 1'b0;
    logic         rst;
    logic         en;
    logic         div_ld;
    logic [W-1:0] div_val;
    logic         carry;
    logic         exc_sq;
    logic [W-1:0] cnt;
    logic         ld_pend;
`ifdef EXC_DIV_QUAD_EN
    logic         exc_quad;
`endif

    exc_div #(.WIDTH(W), .DIV_RESET(DR)) dut (
        .mclk    (mclk),
        .rst     (rst),
        .en      (en),
        .div_ld  (div_ld),
        .div_val (div_val),
        .carry   (carry),
        .exc_sq  (exc_sq),
        .cnt     (cnt),
        .ld_pend (ld_pend)
`ifdef EXC_DIV_QUAD_EN
        ,
        .exc_quad(exc_quad)
`endif
    );

    always #5 mclk = ~mclk;

    int checks = 0;
    int errors = 0;
    int edge_n = 0;

    // Model: a period is described by its start edge and its divisor.
    bit m_run, m_carry, m_sq, m_pend, m_quad, m_hadc;
    int m_dcur, m_dshd, m_start, m_lastc;

    int carry_log[$];
    int quad_log[$];
    bit prev_quad;

    function automatic int clampv(input int v);
        return (v < 2) ? 2 : v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at edge %0d: got %0d expected %0d", name, edge_n, act, exp);
        end
    endtask

    task automatic model_edge();
        if (!rst) begin
            m_run = 0; m_carry = 0; m_sq = 0; m_pend = 0; m_quad = 0; m_hadc = 0;
            m_dcur = DR; m_dshd = DR;
        end else if (!m_run) begin
            m_carry = 0;
            if (div_ld) begin m_dcur = clampv(int'(div_val)); m_dshd = m_dcur; end
            if (en) begin m_run = 1; m_start = edge_n; end
        end else if (!en) begin
            m_run = 0; m_carry = 0; m_sq = 0; m_quad = 0; m_hadc = 0;
            if (div_ld) begin m_dcur = clampv(int'(div_val)); m_dshd = m_dcur; end
            else if (m_pend) m_dcur = m_dshd;
            m_pend = 0;
        end else if (edge_n - m_start == m_dcur) begin
            m_carry = 1; m_sq = !m_sq; m_hadc = 1; m_lastc = edge_n; m_start = edge_n;
            if (div_ld) begin m_dcur = clampv(int'(div_val)); m_dshd = m_dcur; end
            else if (m_pend) m_dcur = m_dshd;
            m_pend = 0;
        end else begin
            m_carry = 0;
            if (div_ld) begin m_dshd = clampv(int'(div_val)); m_pend = 1; end
            if (m_hadc && (edge_n - m_lastc == m_dcur / 2)) m_quad = !m_quad;
        end
    endtask

    task automatic step(input int r, input int e, input int l, input int v);
        int exp_cnt;
        rst = (r != 0); en = (e != 0); div_ld = (l != 0); div_val = v[W-1:0];
        @(posedge mclk);
        edge_n++;
        model_edge();
        #1;
        exp_cnt = m_run ? (m_dcur - 1 - (edge_n - m_start)) : 0;
        chk("carry", carry, m_carry);
        chk("exc_sq", exc_sq, m_sq);
        chk("cnt", cnt, exp_cnt);
        chk("ld_pend", ld_pend, m_pend);
        if (carry === 1'b1) carry_log.push_back(edge_n);
`ifdef EXC_DIV_QUAD_EN
        chk("exc_quad", exc_quad, m_quad);
        if (exc_quad !== prev_quad) quad_log.push_back(edge_n);
        prev_quad = exc_quad;
`endif
    endtask

    task automatic run_until_cnt(input int target, input int maxc, input int e);
        int n = 0;
        while (cnt !== target[W-1:0] && n < maxc) begin
            step(1, e, 0, 0);
            n++;
        end
        chk("reach_cnt", (cnt === target[W-1:0]) ? 1 : 0, 1);
    endtask

    function automatic int gap(input int i);
        return (carry_log.size() > i && i > 0) ? carry_log[i] - carry_log[i-1] : -1;
    endfunction

    initial begin
        int e0, ld_edge, n;
        prev_quad = 1'b0;
        rst = 1'b0; en = 1'b0; div_ld = 1'b0; div_val = '0;

        // Reset overrides en and div_ld
        step(0, 1, 1, 5);
        step(0, 1, 1, 5);
        chk("rst_cnt", cnt, 0);
        chk("rst_carry", carry, 0);
        chk("rst_pend", ld_pend, 0);

        // Release with en held: D=100
        step(1, 1, 0, 0);
        e0 = edge_n;
        chk("entry_cnt", cnt, 99);
        repeat (249) step(1, 1, 0, 0);
        chk("first_carry", (carry_log.size() > 0) ? carry_log[0] - e0 : -1, 100);
        chk("carry_gap100", gap(1), 100);

        // Shadow load of 10 at cnt=40
        carry_log.delete();
        run_until_cnt(40, 200, 1);
        step(1, 1, 1, 10);
        ld_edge = edge_n;
        n = 0;
        while (ld_pend === 1'b1 && n < 200) begin step(1, 1, 0, 0); n++; end
        chk("ld_pend_span", edge_n - ld_edge + 1, 41);
        repeat (25) step(1, 1, 0, 0);
        chk("boundary_carry", (carry_log.size() > 0) ? carry_log[0] - ld_edge : -1, 40);
        chk("carry_gap10a", gap(1), 10);
        chk("carry_gap10b", gap(2), 10);

        // Clamp of 0 and 1 in IDLE
        step(1, 0, 0, 0);
        step(1, 0, 1, 0);
        step(1, 0, 1, 1);
        carry_log.delete();
        step(1, 1, 0, 0);
        repeat (9) step(1, 1, 0, 0);
        chk("clamp_gap_a", gap(1), 2);
        chk("clamp_gap_b", gap(3), 2);

        // en dropped at cnt=5 with D=20
        step(1, 0, 0, 0);
        step(1, 0, 1, 20);
        step(1, 1, 0, 0);
        run_until_cnt(5, 100, 1);
        step(1, 0, 0, 0);
        chk("drop_cnt", cnt, 0);
        chk("drop_carry", carry, 0);
        chk("drop_sq", exc_sq, 0);
        carry_log.delete();
        step(1, 1, 0, 0);
        e0 = edge_n;
        repeat (20) step(1, 1, 0, 0);
        chk("reentry_carry", (carry_log.size() > 0) ? carry_log[0] - e0 : -1, 20);

        // One-edge reset mid-period
        step(1, 1, 0, 0);
        step(0, 1, 0, 0);
        chk("midrst_cnt", cnt, 0);
        chk("midrst_sq", exc_sq, 0);
        step(1, 1, 0, 0);
        chk("restart_cnt", cnt, DR - 1);

`ifdef EXC_DIV_QUAD_EN
        step(1, 0, 0, 0);
        step(1, 0, 1, 8);
        carry_log.delete();
        quad_log.delete();
        step(1, 1, 0, 0);
        repeat (30) step(1, 1, 0, 0);
        chk("quad_offset8", (carry_log.size() > 0 && quad_log.size() > 0) ? quad_log[0] - carry_log[0] : -1, 4);
        chk("quad_period8", (quad_log.size() > 1) ? quad_log[1] - quad_log[0] : -1, 8);
`endif

        // Randomized traffic
        for (int i = 0; i < 4000; i++) begin
            int r, e, l, v;
            r = ($urandom_range(0, 299) != 0) ? 1 : 0;
            e = ($urandom_range(0, 29) != 0) ? 1 : 0;
            l = ($urandom_range(0, 12) == 0 && e != 0) ? 1 : 0;
            v = $urandom_range(0, 14);
            step(r, e, l, v);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/exc_div.md
EXC_DIV -- requirements
Module: exc_div

Interface
REQ-001 The block SHALL provide parameter WIDTH, default 16, as the width of the divisor and counter.
REQ-002 The block SHALL provide parameter DIV_RESET, default 100, as the divisor in effect after reset.
REQ-003 The block SHALL provide port mclk  input  1  master clock; all state SHALL update on the rising edge.
REQ-004 The block SHALL provide port rst  input  1  reset, synchronous and active-low.
REQ-005 The block SHALL provide port en  input  1  run enable.
REQ-006 The block SHALL provide port div_ld  input  1  one-cycle strobe that loads div_val.
REQ-007 The block SHALL provide port div_val  input  WIDTH  requested divisor D, in mclk cycles per carry period.
REQ-008 The block SHALL provide port carry  output  1  registered period pulse that feeds the downstream timing control's carry input.
REQ-009 The block SHALL provide port exc_sq  output  1  registered LVDT excitation square wave.
REQ-010 The block SHALL provide port cnt  output  WIDTH  current down-counter value.
REQ-011 The block SHALL provide port ld_pend  output  1  high while a shadowed divisor waits for a period boundary.

Function
REQ-012 The block SHALL implement two states: IDLE and RUN.
REQ-013 IDLE SHALL go to RUN on the edge where en=1, loading cnt with D-1 at that edge.
REQ-014 RUN SHALL go to IDLE on any edge where en=0; on that edge cnt SHALL clear to 0, carry to 0 and exc_sq to 0.
REQ-015 In RUN, cnt SHALL decrement by 1 per edge, and on the edge leaving 0 it SHALL reload with D-1 (the reload edge).
REQ-016 carry SHALL be glitch-free, driven directly from a flop, because downstream logic uses it as a clock.
REQ-017 If RUN is entered at edge k, carry SHALL be high for exactly one cycle, from edge k+D to edge k+D+1, and then every D edges.
REQ-018 exc_sq SHALL toggle on each edge where carry rises, giving a period of 2*D mclk cycles and a 50% duty cycle.
REQ-019 A div_val below 2 SHALL be clamped to 2.
REQ-020 Values of div_val are unsigned, and D-1 SHALL never wrap.
REQ-021 In IDLE, div_ld SHALL write the active divisor directly, and ld_pend SHALL stay 0.
REQ-022 In RUN, div_ld SHALL write a shadow register and set ld_pend; the shadow SHALL become active at the next reload edge, and ld_pend SHALL clear on that edge.
REQ-023 A div_ld coincident with a reload edge SHALL take effect at that reload, with ld_pend remaining 0.
REQ-024 A second div_ld while ld_pend=1 SHALL overwrite the shadow, and only the last value SHALL apply.
REQ-025 en rising together with div_ld in IDLE SHALL use the new div_val for the first period.
REQ-026 Clearing en while ld_pend=1 SHALL make the shadow value active on the RUN->IDLE edge and clear ld_pend.

Reset
REQ-027 On any edge with rst=0, the block SHALL force state=IDLE, cnt=0, carry=0, exc_sq=0, ld_pend=0, active divisor=DIV_RESET and shadow=DIV_RESET.
REQ-028 Reset SHALL override en and div_ld on the same edge.
REQ-029 Reset asserted mid-period SHALL abandon the period, with no carry pulse emitted.
REQ-030 After rst returns to 1, the block SHALL remain in IDLE until en is sampled high.

Configuration
REQ-031 When macro EXC_DIV_QUAD_EN is defined, the block SHALL add port exc_quad  output  1, a registered quadrature excitation.
REQ-032 With EXC_DIV_QUAD_EN defined, exc_quad SHALL toggle once per period, floor(D/2) edges after each carry rising edge.
REQ-033 With EXC_DIV_QUAD_EN defined, exc_quad SHALL reset to 0 and SHALL clear to 0 on RUN->IDLE.
REQ-034 When EXC_DIV_QUAD_EN is undefined, the exc_quad port and its logic SHALL be absent, and all other behaviour SHALL be identical.

Verification
REQ-035 Reset release with en=1 held (DIV_RESET=100) -> first carry 100 edges after RUN entry, repeating every 100 edges, each pulse exactly 1 cycle, exc_sq period 200.
REQ-036 div_ld with div_val=10 during a 100-cycle period at cnt=40 -> ld_pend=1 for 41 edges, current period completes at 100, following carries every 10 edges.
REQ-037 div_val=0 and div_val=1 loaded in IDLE, then en=1 -> carry every 2 edges and exc_sq toggling every 2 edges, with no counter wrap.
REQ-038 en dropped at cnt=5 with D=20 -> IDLE next edge, carry=0, exc_sq=0, cnt=0; en reasserted -> first carry 20 edges later.
REQ-039 rst=0 asserted for one edge mid-period with en=1 -> all outputs zero and divisor=DIV_RESET; block restarts in RUN on the following en-sampled edge.
REQ-040 With EXC_DIV_QUAD_EN and D=8 -> exc_quad toggles 4 edges after each carry, with period 16; with D=9 -> 4 edges after each carry.
